id_ex_reg: RTL and testbench

ID/EX pipeline register for the five-stage MIPS core. Captures the decode-stage results (instruction, PC+8, register-file read data, the 32-bit extended immediate, write-back destination and control word) on each clock edge and presents them to the execute stage. When the hazard unit signals a load-use stall, it inserts a bubble. It also ages each instruction's Tnew (cycles until its result is available) for the forwarding and stall logic.

---
 rtl/id_ex_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: captures decode results, inserts bubbles on load-use stalls, ages Tnew.
// Optional bubble performance counter built only when ID_EX_PERF_CNT_EN is defined.

package id_ex_reg_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CTRL_W = 12;

    typedef struct packed {
        logic [3:0] alu_op;
        logic       alusrc;
        logic       regwrite;
        logic       memwrite;
        logic [1:0] memtoreg;
        logic       ext_used;
        logic [1:0] unused;
    } ctrl_t;

    typedef struct packed {
        logic [XLEN-1:0]  instr;
        logic [XLEN-1:0]  pc8;
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  ext_imm;
        logic [REG_W-1:0] a3;
        ctrl_t            ctrl;
    } id_ex_pay_t;

endpackage

module id_ex_reg
    import id_ex_reg_pkg::*;
#(
    parameter int unsigned TNEW_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [31:0]       id_instr,
    input  logic [31:0]       id_pc8,
    input  logic [31:0]       id_rs_data,
    input  logic [31:0]       id_rt_data,
    input  logic [31:0]       id_ext_imm,
    input  logic [4:0]        id_a3,
    input  logic [11:0]       id_ctrl,
    input  logic [TNEW_W-1:0] id_tnew,
    output logic [31:0]       ex_instr,
    output logic [31:0]       ex_pc8,
    output logic [31:0]       ex_rs_data,
    output logic [31:0]       ex_rt_data,
    output logic [31:0]       ex_ext_imm,
    output logic [4:0]        ex_a3,
    output logic [11:0]       ex_ctrl,
    output logic [TNEW_W-1:0] ex_tnew,
    output logic              ex_valid,
    output logic [31:0]       bubble_cnt
);

    id_ex_pay_t        pay_d, pay_q;
    logic [TNEW_W-1:0] tnew_d, tnew_q;
    logic              valid_d, valid_q;
    ctrl_t             id_ctrl_s;

    assign id_ctrl_s = ctrl_t'(id_ctrl);

    // Next EX contents: zero bubble on stall, otherwise the ID payload with $0 writes suppressed.
    always_comb begin
        pay_d   = '0;
        tnew_d  = '0;
        valid_d = 1'b0;
        if (!stall) begin
            pay_d.instr   = id_instr;
            pay_d.pc8     = id_pc8;
            pay_d.rs_data = id_rs_data;
            pay_d.rt_data = id_rt_data;
            pay_d.ext_imm = id_ext_imm;
            pay_d.a3      = id_a3;
            pay_d.ctrl    = id_ctrl_s;
            if (id_a3 == REG_W'(0)) begin
                pay_d.ctrl.regwrite = 1'b0;
            end
            tnew_d  = (id_tnew != '0) ? (id_tnew - TNEW_W'(1)) : '0;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pay_q   <= '0;
            tnew_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            pay_q   <= pay_d;
            tnew_q  <= tnew_d;
            valid_q <= valid_d;
        end
    end

    assign ex_instr   = pay_q.instr;
    assign ex_pc8     = pay_q.pc8;
    assign ex_rs_data = pay_q.rs_data;
    assign ex_rt_data = pay_q.rt_data;
    assign ex_ext_imm = pay_q.ext_imm;
    assign ex_a3      = pay_q.a3;
    assign ex_ctrl    = CTRL_W'(pay_q.ctrl);
    assign ex_tnew    = tnew_q;
    assign ex_valid   = valid_q;

`ifdef ID_EX_PERF_CNT_EN
    logic [XLEN-1:0] bubble_cnt_d, bubble_cnt_q;

    // Free-running bubble count; wraps silently.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (stall) begin
            bubble_cnt_d = bubble_cnt_q + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubble_cnt = bubble_cnt_q;
`else
    assign bubble_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg; expected counter values follow ID_EX_PERF_CNT_EN.

module tb_id_ex_reg;

    localparam int unsigned TNEW_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              stall;
    logic [31:0]       id_instr, id_pc8, id_rs_data, id_rt_data, id_ext_imm;
    logic [4:0]        id_a3;
    logic [11:0]       id_ctrl;
    logic [TNEW_W-1:0] id_tnew;
    logic [31:0]       ex_instr, ex_pc8, ex_rs_data, ex_rt_data, ex_ext_imm;
    logic [4:0]        ex_a3;
    logic [11:0]       ex_ctrl;
    logic [TNEW_W-1:0] ex_tnew;
    logic              ex_valid;
    logic [31:0]       bubble_cnt;

    int tests_run = 0;
    int tests_failed = 0;
    int bub = 0;

    id_ex_reg #(.TNEW_W(TNEW_W)) dut (
        .clk(clk), .reset(reset), .stall(stall),
        .id_instr(id_instr), .id_pc8(id_pc8), .id_rs_data(id_rs_data),
        .id_rt_data(id_rt_data), .id_ext_imm(id_ext_imm), .id_a3(id_a3),
        .id_ctrl(id_ctrl), .id_tnew(id_tnew),
        .ex_instr(ex_instr), .ex_pc8(ex_pc8), .ex_rs_data(ex_rs_data),
        .ex_rt_data(ex_rt_data), .ex_ext_imm(ex_ext_imm), .ex_a3(ex_a3),
        .ex_ctrl(ex_ctrl), .ex_tnew(ex_tnew), .ex_valid(ex_valid),
        .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_exp(input int n);
`ifdef ID_EX_PERF_CNT_EN
        return 32'(n);
`else
        return 32'h0;
`endif
    endfunction

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc8,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] imm, input logic [4:0] a3,
                         input logic [11:0] ctrl, input logic [TNEW_W-1:0] tnew);
        id_instr = instr; id_pc8 = pc8; id_rs_data = rs; id_rt_data = rt;
        id_ext_imm = imm; id_a3 = a3; id_ctrl = ctrl; id_tnew = tnew;
    endtask

    // Advance one edge; outputs are sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_bubble(input string tag);
        check({tag, "_instr"}, ex_instr, 32'h0);
        check({tag, "_pc8"}, ex_pc8, 32'h0);
        check({tag, "_rs"}, ex_rs_data, 32'h0);
        check({tag, "_rt"}, ex_rt_data, 32'h0);
        check({tag, "_imm"}, ex_ext_imm, 32'h0);
        check({tag, "_a3"}, 32'(ex_a3), 32'h0);
        check({tag, "_ctrl"}, 32'(ex_ctrl), 32'h0);
        check({tag, "_tnew"}, 32'(ex_tnew), 32'h0);
        check({tag, "_valid"}, 32'(ex_valid), 32'h0);
    endtask

    initial begin
        reset = 1'b1;
        stall = 1'b0;
        drive(32'hDEADBEEF, 32'h11111111, 32'h22222222, 32'h33333333,
              32'h44444444, 5'd9, 12'hFFF, 2'd3);
        step();
        step();
        check_bubble("reset");
        check("reset_cnt", bubble_cnt, 32'h0);

        // addi $8,$0,-1 : alu_op=C, alusrc, regwrite, ext_used
        reset = 1'b0;
        drive(32'h2008FFFF, 32'h00400008, 32'h0, 32'h12345678,
              32'hFFFFFFFF, 5'd8, 12'hCC4, 2'd1);
        step();
        check("load_instr", ex_instr, 32'h2008FFFF);
        check("load_pc8", ex_pc8, 32'h00400008);
        check("load_rs", ex_rs_data, 32'h0);
        check("load_rt", ex_rt_data, 32'h12345678);
        check("load_imm", ex_ext_imm, 32'hFFFFFFFF);
        check("load_a3", 32'(ex_a3), 32'd8);
        check("load_ctrl", 32'(ex_ctrl), 32'hCC4);
        check("load_tnew", 32'(ex_tnew), 32'd0);
        check("load_valid", 32'(ex_valid), 32'd1);

        id_tnew = 2'd2;
        step();
        check("tnew2", 32'(ex_tnew), 32'd1);
        id_tnew = 2'd0;
        step();
        check("tnew0", 32'(ex_tnew), 32'd0);
        id_tnew = 2'd3;
        step();
        check("tnew3", 32'(ex_tnew), 32'd2);

        // lw $9,4($8) held in ID across a 3-cycle stall
        drive(32'h8D090004, 32'h00400010, 32'hFFFFFFFF, 32'hA5A5A5A5,
              32'h00000004, 5'd9, 12'h0C9, 2'd2);
        stall = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            step();
            bub++;
            check_bubble($sformatf("stall%0d", k));
            check($sformatf("stall%0d_cnt", k), bubble_cnt, cnt_exp(bub));
        end
        stall = 1'b0;
        step();
        check("post_instr", ex_instr, 32'h8D090004);
        check("post_pc8", ex_pc8, 32'h00400010);
        check("post_rs", ex_rs_data, 32'hFFFFFFFF);
        check("post_rt", ex_rt_data, 32'hA5A5A5A5);
        check("post_imm", ex_ext_imm, 32'h00000004);
        check("post_a3", 32'(ex_a3), 32'd9);
        check("post_ctrl", 32'(ex_ctrl), 32'h0C9);
        check("post_tnew", 32'(ex_tnew), 32'd1);
        check("post_valid", 32'(ex_valid), 32'd1);
        check("post_cnt", bubble_cnt, cnt_exp(bub));

        // $0 destination suppresses regwrite (bit 6), other bits pass
        drive(32'h00001025, 32'h00400018, 32'h5, 32'h6, 32'h7, 5'd0, 12'hFFF, 2'd1);
        step();
        check("zero_a3", 32'(ex_a3), 32'd0);
        check("zero_ctrl", 32'(ex_ctrl), 32'hFBF);
        check("zero_valid", 32'(ex_valid), 32'd1);
        id_a3 = 5'd31;
        step();
        check("a3_31", 32'(ex_a3), 32'd31);
        check("a3_31_ctrl", 32'(ex_ctrl), 32'hFFF);

        // reset beats stall, counter clears and does not count
        reset = 1'b1;
        stall = 1'b1;
        step();
        bub = 0;
        check_bubble("rst_stall");
        check("rst_stall_cnt", bubble_cnt, 32'h0);
        step();
        check("rst_stall2_cnt", bubble_cnt, 32'h0);

        // first cycle after reset loads normally
        reset = 1'b0;
        stall = 1'b0;
        drive(32'h03E00008, 32'h00400020, 32'h00400100, 32'h0, 32'h0, 5'd0, 12'h000, 2'd0);
        step();
        check("after_rst_instr", ex_instr, 32'h03E00008);
        check("after_rst_rs", ex_rs_data, 32'h00400100);
        check("after_rst_valid", 32'(ex_valid), 32'd1);
        check("after_rst_cnt", bubble_cnt, 32'h0);

`ifdef ID_EX_PERF_CNT_EN
        force dut.bubble_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.bubble_cnt_q;
`endif
        stall = 1'b1;
        step();
        check("wrap1_valid", 32'(ex_valid), 32'd0);
`ifdef ID_EX_PERF_CNT_EN
        check("wrap1_cnt", bubble_cnt, 32'hFFFFFFFF);
`else
        check("wrap1_cnt", bubble_cnt, 32'h0);
`endif
        step();
        check("wrap2_cnt", bubble_cnt, 32'h0);
        stall = 1'b0;
        step();
        check("final_valid", 32'(ex_valid), 32'd1);
        check("final_cnt", bubble_cnt, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
